// File: rtl/dqn_pkg.sv
// Shared DQN encodings: layer ids, one-hot layer selects and the
// target-sync FSM state set.
package dqn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [1:0] LAYER_H1  = 2'd1;
  localparam logic [1:0] LAYER_H2  = 2'd2;
  localparam logic [1:0] LAYER_OUT = 2'd3;

  localparam logic [2:0] SEL_H1  = 3'b001;
  localparam logic [2:0] SEL_H2  = 3'b010;
  localparam logic [2:0] SEL_OUT = 3'b100;

  function automatic logic [2:0] layer_onehot(input logic [1:0] layer);
    logic [2:0] sel;
    sel = 3'b000;
    unique case (1'b1)
      layer == LAYER_H1:  sel = SEL_H1;
      layer == LAYER_H2:  sel = SEL_H2;
      layer == LAYER_OUT: sel = SEL_OUT;
      default:            sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/target_net_update_ctrl_if.sv
// Source-read / target-write bus between the sync controller and the
// online/target weight memories.
interface target_net_update_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 5,
  parameter int MAX_FANIN  = 32
);

  logic                            o_src_rd_en;
  logic [1:0]                      o_src_layer;
  logic [MEM_WIDTH-1:0]            o_src_addr;
  logic                            i_src_valid;
  logic [DATA_WIDTH*MAX_FANIN-1:0] i_src_weight;
  logic [DATA_WIDTH-1:0]           i_src_bias;
  logic                            o_mem_enable;
  logic                            o_rw_mem;
  logic                            o_update_weight;
  logic [2:0]                      o_layer_sel;
  logic [MEM_WIDTH-1:0]            o_addr;
  logic [DATA_WIDTH*MAX_FANIN-1:0] o_weight;
  logic [DATA_WIDTH-1:0]           o_bias;

  modport master (
    output o_src_rd_en, o_src_layer, o_src_addr,
    output o_mem_enable, o_rw_mem, o_update_weight,
    output o_layer_sel, o_addr, o_weight, o_bias,
    input  i_src_valid, i_src_weight, i_src_bias
  );

  modport slave (
    input  o_src_rd_en, o_src_layer, o_src_addr,
    input  o_mem_enable, o_rw_mem, o_update_weight,
    input  o_layer_sel, o_addr, o_weight, o_bias,
    output i_src_valid, i_src_weight, i_src_bias
  );

endinterface

// File: rtl/target_net_update_ctrl_period.sv
// Training-step counter; hit flags that a full update period has elapsed.
module target_update_period_counter #(
  parameter int PERIOD = 100,
  parameter int CNT_W  = $clog2(PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == CNT_W'(PERIOD));

endmodule

// File: rtl/target_net_update_ctrl.sv
// Copies online-net weights/biases into the target net, node by node,
// every UPDATE_PERIOD training steps or on demand.
module target_net_update_ctrl
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int MEM_WIDTH           = 5,
  parameter int NODE_WIDTH_HIDDEN_1 = 32,
  parameter int NODE_WIDTH_HIDDEN_2 = 32,
  parameter int NODE_WIDTH_OUTPUT   = 3,
  parameter int MAX_FANIN           = 32,
  parameter int UPDATE_PERIOD       = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_train_done,
  input  logic i_force_update,
  target_net_update_ctrl_if.master bus,
  output logic o_busy,
  output logic o_update_done
);

  localparam int CNT_W = $clog2(UPDATE_PERIOD + 1);
  localparam int WW    = DATA_WIDTH * MAX_FANIN;

  state_t               state, state_nx;
  logic [1:0]           layer;
  logic [MEM_WIDTH-1:0] addr;
  logic [MEM_WIDTH-1:0] last_addr;
  logic [WW-1:0]        wreg;
  logic [DATA_WIDTH-1:0] breg;
  logic [CNT_W-1:0]     step_count;
  logic                 period_hit;
  logic                 step_inc;
  logic                 start;
  logic                 node_end;

  assign start    = (state == ST_IDLE) && (period_hit || i_force_update);
  assign node_end = (addr == last_addr);
  // Saturate so a long sync cannot wrap the count past the threshold.
  assign step_inc = i_train_done && (step_count != CNT_W'(UPDATE_PERIOD));

  target_update_period_counter #(
    .PERIOD (UPDATE_PERIOD),
    .CNT_W  (CNT_W)
  ) u_period (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (step_inc),
    .clear (start),
    .count (step_count),
    .hit   (period_hit)
  );

  always_comb begin
    last_addr = MEM_WIDTH'(NODE_WIDTH_OUTPUT - 1);
    unique case (1'b1)
      layer == LAYER_H1: last_addr = MEM_WIDTH'(NODE_WIDTH_HIDDEN_1 - 1);
      layer == LAYER_H2: last_addr = MEM_WIDTH'(NODE_WIDTH_HIDDEN_2 - 1);
      default:           last_addr = MEM_WIDTH'(NODE_WIDTH_OUTPUT - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_REQ;
      ST_REQ:   state_nx = ST_WAIT;
      ST_WAIT:  if (bus.i_src_valid) state_nx = ST_WRITE;
      ST_WRITE: begin
        if (node_end && layer == LAYER_OUT) state_nx = ST_DONE;
        else                                state_nx = ST_REQ;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= '0;
      addr  <= '0;
      wreg  <= '0;
      breg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            layer <= LAYER_H1;
            addr  <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.i_src_valid) begin
            wreg <= bus.i_src_weight;
            breg <= bus.i_src_bias;
          end
        end
        ST_WRITE: begin
          if (!node_end) begin
            addr <= addr + MEM_WIDTH'(1);
          end else if (layer != LAYER_OUT) begin
            addr  <= '0;
            layer <= layer + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy              = (state != ST_IDLE);
    o_update_done       = 1'b0;
    bus.o_src_rd_en     = 1'b0;
    bus.o_src_layer     = '0;
    bus.o_src_addr      = '0;
    bus.o_mem_enable    = 1'b0;
    bus.o_rw_mem        = 1'b1;
    bus.o_update_weight = 1'b0;
    bus.o_layer_sel     = '0;
    bus.o_addr          = '0;
    bus.o_weight        = '0;
    bus.o_bias          = '0;
    unique case (state)
      ST_REQ: begin
        bus.o_src_rd_en = 1'b1;
        bus.o_src_layer = layer;
        bus.o_src_addr  = addr;
      end
      ST_WRITE: begin
        bus.o_mem_enable    = 1'b1;
        bus.o_rw_mem        = 1'b0;
        bus.o_update_weight = 1'b1;
        bus.o_layer_sel     = layer_onehot(layer);
        bus.o_addr          = addr;
        bus.o_weight        = wreg;
        bus.o_bias          = breg;
      end
      ST_DONE: o_update_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_target_net_update_ctrl.sv
// Directed bench for target_net_update_ctrl: reset, period start,
// full syncs, delayed source, ignored force and mid-sync reset.
module tb_target_net_update_ctrl;
  import dqn_pkg::*;

  localparam int DW = 32;
  localparam int MW = 5;
  localparam int MF = 32;
  localparam int UP = 4;
  localparam int WW = DW * MF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic train_done = 1'b0;
  logic force_update = 1'b0;
  logic busy;
  logic update_done;

  int n_checks = 0;
  int n_fail = 0;

  target_net_update_ctrl_if #(
    .DATA_WIDTH (DW),
    .MEM_WIDTH  (MW),
    .MAX_FANIN  (MF)
  ) bus ();

  target_net_update_ctrl #(
    .DATA_WIDTH          (DW),
    .MEM_WIDTH           (MW),
    .NODE_WIDTH_HIDDEN_1 (32),
    .NODE_WIDTH_HIDDEN_2 (32),
    .NODE_WIDTH_OUTPUT   (3),
    .MAX_FANIN           (MF),
    .UPDATE_PERIOD       (UP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_train_done   (train_done),
    .i_force_update (force_update),
    .bus            (bus),
    .o_busy         (busy),
    .o_update_done  (update_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tr;
    logic        fu;
    logic        sv;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_weight(input int l, input int a);
    logic [WW-1:0] w;
    for (int k = 0; k < MF; k++)
      w[k*DW +: DW] = {8'(l), 8'(a), 8'(k), 8'hC3};
    return w;
  endfunction

  function automatic logic [DW-1:0] mk_bias(input int l, input int a);
    return {8'hB1, 8'(l), 8'(a), 8'h5A};
  endfunction

  function automatic int nodes(input int l);
    return (l == 1) ? 32 : (l == 2) ? 32 : 3;
  endfunction

  function automatic logic [2:0] sel_of(input int l);
    return (l == 1) ? 3'b001 : (l == 2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [19:0] ex(input bit b, input bit rd,
      input int sl, input int sa, input bit men, input bit rw,
      input bit upd, input logic [2:0] sel, input int ad);
    return {b, rd, 2'(sl), 5'(sa), men, rw, upd, sel, 5'(ad)};
  endfunction

  function automatic logic [19:0] obs20();
    return {busy, bus.o_src_rd_en, bus.o_src_layer, bus.o_src_addr,
            bus.o_mem_enable, bus.o_rw_mem, bus.o_update_weight,
            bus.o_layer_sel, bus.o_addr};
  endfunction

  task automatic chk_reset(input string name);
    chk(name, {obs20(), update_done, |bus.o_weight, |bus.o_bias},
        {ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0), 3'b000});
  endtask

  task automatic chk_weight(input string name, input logic [WW-1:0] exp);
    n_checks++;
    if (bus.o_weight !== exp) begin
      n_fail++;
      for (int k = 0; k < MF; k++) begin
        if (bus.o_weight[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", name, k,
                   bus.o_weight[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Cycle-by-cycle source model and write checker from the current sample.
  task automatic run_sync(input int sl, input int sa,
      input int dl, input int da, input int dx,
      input int al, input int aa, input bit inject,
      output int cycles, output int writes, output int dones);
    int  el = sl;
    int  ea = sa;
    int  wait_cnt = 0;
    int  ci = 0;
    bit  given = 0;
    bit  fin = 0;
    bit  is_dly;
    cycles = 0;
    writes = 0;
    dones = 0;
    while (!fin && ci < 2000) begin
      train_done = 1'b0;
      force_update = 1'b0;
      bus.i_src_valid = 1'b0;
      bus.i_src_weight = '1;
      bus.i_src_bias = '1;
      is_dly = (el == dl) && (ea == da);
      if (busy) cycles++;
      if (bus.o_src_rd_en) begin
        chk("src_node", {bus.o_src_layer, bus.o_src_addr},
            {2'(el), 5'(ea)});
        if (el == al && ea == aa) begin
          rst_n = 1'b0;
          #1;
          chk_reset("abort_reset");
          chk("abort_count", 64'(dut.step_count), 0);
          fin = 1;
        end
        wait_cnt = is_dly ? 1 + dx : 1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.i_src_valid = 1'b1;
          bus.i_src_weight = mk_weight(el, ea);
          bus.i_src_bias = is_dly ? 32'hDEADBEEF : mk_bias(el, ea);
          given = 1;
        end else begin
          chk("wait_hold", {busy, bus.o_src_rd_en, bus.o_mem_enable},
              3'b100);
        end
      end
      if (bus.o_mem_enable) begin
        chk("wr_given", 64'(given), 1);
        chk("wr_ctl", {bus.o_rw_mem, bus.o_update_weight,
            bus.o_layer_sel, bus.o_addr},
            {1'b0, 1'b1, sel_of(el), 5'(ea)});
        chk_weight("wr_weight", mk_weight(el, ea));
        chk("wr_bias", 64'(bus.o_bias),
            64'(is_dly ? 32'hDEADBEEF : mk_bias(el, ea)));
        given = 0;
        writes++;
        if (ea < nodes(el) - 1) begin
          ea++;
        end else begin
          ea = 0;
          el++;
        end
      end
      if (update_done) begin
        dones++;
        fin = 1;
      end
      if (inject) begin
        if (ci == 10 || ci == 20 || ci == 30) train_done = 1'b1;
        if (ci == 15 || ci == 40) force_update = 1'b1;
      end
      ci++;
      if (!fin) begin
        @(posedge clk);
        #1;
      end
    end
    if (!fin) chk("sync_timeout", 64'(ci), 0);
  endtask

  task automatic force_start();
    force_update = 1'b1;
    @(posedge clk);
    #1;
    force_update = 1'b0;
  endtask

  task automatic idle_after(input string name);
    @(posedge clk);
    #1;
    chk(name, {busy, update_done}, 2'b00);
  endtask

  int cyc, wr, dn;

  initial begin
    bus.i_src_valid = 1'b0;
    bus.i_src_weight = '1;
    bus.i_src_bias = '1;

    tbl[0] = '{1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[1] = '{1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[2] = '{1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[3] = '{1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[4] = '{1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[5] = '{1'b0, 1'b0, 1'b0, ex(1, 1, 1, 0, 0, 1, 0, 3'b000, 0)};
    tbl[6] = '{1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[7] = '{1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tbl[8] = '{1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 1, 0, 1, 3'b001, 0)};
    tbl[9] = '{1'b0, 1'b0, 1'b0, ex(1, 1, 1, 1, 0, 1, 0, 3'b000, 0)};

    train_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_hold");
    chk("reset_count", 64'(dut.step_count), 0);
    train_done = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      train_done = tbl[i].tr;
      force_update = tbl[i].fu;
      bus.i_src_valid = tbl[i].sv;
      bus.i_src_weight = tbl[i].sv ? mk_weight(1, 0) : '1;
      bus.i_src_bias = tbl[i].sv ? mk_bias(1, 0) : '1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {obs20(), update_done},
          {tbl[i].exp, 1'b0});
      if (i == 8) begin
        chk_weight("vec8_weight", mk_weight(1, 0));
        chk("vec8_bias", 64'(bus.o_bias), 64'(mk_bias(1, 0)));
      end
    end
    train_done = 1'b0;
    bus.i_src_valid = 1'b0;

    run_sync(1, 1, 0, 0, 0, 0, 0, 0, cyc, wr, dn);
    chk("period_writes", 64'(wr), 66);
    chk("period_cycles", 64'(cyc), 199);
    chk("period_done", 64'(dn), 1);
    idle_after("period_idle");

    force_start();
    run_sync(1, 0, 0, 0, 0, 0, 0, 0, cyc, wr, dn);
    chk("full_writes", 64'(wr), 67);
    chk("full_cycles", 64'(cyc), 202);
    chk("full_done", 64'(dn), 1);
    idle_after("full_idle");

    force_start();
    run_sync(1, 0, 2, 7, 5, 0, 0, 0, cyc, wr, dn);
    chk("dly_writes", 64'(wr), 67);
    chk("dly_cycles", 64'(cyc), 207);
    chk("dly_done", 64'(dn), 1);
    idle_after("dly_idle");

    force_start();
    run_sync(1, 0, 0, 0, 0, 0, 0, 1, cyc, wr, dn);
    chk("inj_writes", 64'(wr), 67);
    chk("inj_done", 64'(dn), 1);
    idle_after("inj_force_ignored");
    chk("inj_count", 64'(dut.step_count), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("inj_still_idle", 64'(busy), 0);
    train_done = 1'b1;
    @(posedge clk);
    #1;
    train_done = 1'b0;
    chk("inj_4th_idle", 64'(busy), 0);
    @(posedge clk);
    #1;
    chk("inj_restart", {busy, bus.o_src_rd_en, bus.o_src_layer,
        bus.o_src_addr}, {1'b1, 1'b1, 2'd1, 5'd0});
    run_sync(1, 0, 0, 0, 0, 0, 0, 0, cyc, wr, dn);
    chk("inj2_done", 64'(dn), 1);
    idle_after("inj2_idle");

    force_start();
    run_sync(1, 0, 0, 0, 0, 3, 1, 0, cyc, wr, dn);
    chk("abort_no_done", 64'(dn), 0);
    chk("abort_writes", 64'(wr), 65);
    @(negedge clk);
    rst_n = 1'b1;
    idle_after("abort_idle");
    force_start();
    chk("abort_restart", {busy, bus.o_src_rd_en, bus.o_src_layer,
        bus.o_src_addr}, {1'b1, 1'b1, 2'd1, 5'd0});
    run_sync(1, 0, 0, 0, 0, 0, 0, 0, cyc, wr, dn);
    chk("restart_writes", 64'(wr), 67);
    chk("restart_done", 64'(dn), 1);
    idle_after("restart_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
